// File: rtl/seq_detector_prog.sv
// Serial bit-pattern detector with a run-time loadable pattern, length and overlap mode.
// det is combinational in the cycle the final bit arrives; det_q, cfg_err and match_cnt are registered.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0001_0110,
    parameter int                 RST_LEN     = 5,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic               det_q,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt
);

    // Only MAX_LEN-1 past bits are ever needed; the current bit completes the window.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_det_q;
    logic               r_cfg_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_filled;
    logic               w_match;
    logic               w_det;
    logic               w_cfg_ok;
    logic               w_cfg_acc;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [MAX_LEN-2:0] w_hist_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_window = {r_hist, in_bit};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    // r_len is never zero, so len-1 cannot underflow.
    assign w_filled = (r_fill >= (r_len - LEN_W'(1)));
    assign w_match  = in_valid && w_filled && (((w_window ^ r_pat) & w_mask) == '0);
    assign w_det    = w_match && !rst;

    assign w_cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_cfg_acc = cfg_load && w_cfg_ok;

    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (in_valid) begin
            w_hist_nxt = w_window[MAX_LEN-2:0];
            if (r_fill != LEN_W'(MAX_LEN - 1)) begin
                w_fill_nxt = r_fill + LEN_W'(1);
            end
        end
        // A new config discards history even if the same bit also completed a match.
        if ((w_match && !r_ovl) || w_cfg_acc) begin
            w_fill_nxt = '0;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (cnt_clr) begin
            w_cnt_nxt = '0;
        end else if (w_det && !(&r_cnt)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= RST_PATTERN;
            r_len     <= LEN_W'(RST_LEN);
            r_ovl     <= RST_OVERLAP;
            r_det_q   <= 1'b0;
            r_cfg_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_det_q   <= w_det;
            r_cfg_err <= cfg_load && !w_cfg_ok;
            r_cnt     <= w_cnt_nxt;
            if (w_cfg_acc) begin
                r_pat <= cfg_pattern;
                r_len <= cfg_len;
                r_ovl <= cfg_overlap;
            end
        end
    end

    assign det       = w_det;
    assign det_q     = r_det_q;
    assign cfg_err   = r_cfg_err;
    assign match_cnt = r_cnt;

endmodule
